// File: rtl/comparator_seq.sv
// comparator_seq: multi-cycle magnitude comparator, one CHUNK-bit slice per clock, MSB slice first.
// Ports: i_clk/i_rst_n (async active-low); i_valid/o_ready request handshake with operand_a,
// operand_b, i_signed; o_valid/i_ready result handshake with one-hot o_eq/o_lt/o_gt.
module comparator_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             i_signed,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_eq,
  output logic             o_lt,
  output logic             o_gt
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, a_sh, b_sh, flip;
  logic [CHUNK-1:0] a_s, b_s;
  logic [IW-1:0] idx;
  logic accept, diff, last;
  assign o_ready = state == IDLE;
  assign o_valid = state == DONE;
  assign accept  = i_valid & o_ready;
  // Flipping both MSBs maps two's complement onto offset binary, so the slice compare stays unsigned.
  assign flip = i_signed ? MSB : '0;
  assign a_sh = a_q << (CHUNK * idx);
  assign b_sh = b_q << (CHUNK * idx);
  assign a_s  = a_sh[WIDTH-1 -: CHUNK];
  assign b_s  = b_sh[WIDTH-1 -: CHUNK];
  assign diff = a_s != b_s;
  assign last = idx == IW'(NCHUNK - 1);
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (state == IDLE && i_valid) state_nx = RUN;
    if (state == RUN && (diff || last)) state_nx = DONE;
    if (state == DONE && i_ready) state_nx = IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      idx  <= '0;
      o_eq <= 1'b0;
      o_lt <= 1'b0;
      o_gt <= 1'b0;
    end else if (accept) begin
      a_q  <= operand_a ^ flip;
      b_q  <= operand_b ^ flip;
      idx  <= '0;
      o_eq <= 1'b0;
      o_lt <= 1'b0;
      o_gt <= 1'b0;
    end else if (state == RUN) begin
      if (diff) begin
        o_lt <= a_s < b_s;
        o_gt <= !(a_s < b_s);
        o_eq <= 1'b0;
      end else if (last) begin
        o_eq <= 1'b1;
        o_lt <= 1'b0;
        o_gt <= 1'b0;
      end else idx <= idx + 1'b1;
    end
endmodule

// File: tb/tb_comparator_seq.sv
// tb_comparator_seq: table, directed-sequence and random checks of comparator_seq at three parameter sets.
module tb_comparator_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic vin[3], ordy[3], sg[3], ov[3], irdy[3], eq[3], lt[3], gt[3];
  logic [31:0] opa[3], opb[3];
  int ws[3] = '{32, 8, 16};
  int cs[3] = '{4, 8, 1};
  int checks = 0;
  int failures = 0;

  comparator_seq #(.WIDTH(32), .CHUNK(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[0]), .o_ready(ordy[0]),
    .operand_a(opa[0]), .operand_b(opb[0]), .i_signed(sg[0]), .o_valid(ov[0]),
    .i_ready(irdy[0]), .o_eq(eq[0]), .o_lt(lt[0]), .o_gt(gt[0]));
  comparator_seq #(.WIDTH(8), .CHUNK(8)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[1]), .o_ready(ordy[1]),
    .operand_a(opa[1][7:0]), .operand_b(opb[1][7:0]), .i_signed(sg[1]), .o_valid(ov[1]),
    .i_ready(irdy[1]), .o_eq(eq[1]), .o_lt(lt[1]), .o_gt(gt[1]));
  comparator_seq #(.WIDTH(16), .CHUNK(1)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin[2]), .o_ready(ordy[2]),
    .operand_a(opa[2][15:0]), .operand_b(opb[2][15:0]), .i_signed(sg[2]), .o_valid(ov[2]),
    .i_ready(irdy[2]), .o_eq(eq[2]), .o_lt(lt[2]), .o_gt(gt[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [2:0]  f;
    int          k;
  } vec_t;

  function automatic logic [2:0] flags(input int d);
    return {eq[d], lt[d], gt[d]};
  endfunction

  task automatic chk(input string n, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference: numeric compare of the operands as integers, and position of the first differing slice.
  task automatic model(input int d, input logic [31:0] a_in, input logic [31:0] b_in, input logic s,
                       output logic [2:0] f, output int k);
    int w, c;
    logic [31:0] m, cm, a, b;
    longint av, bv;
    w = ws[d];
    c = cs[d];
    m = (w == 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 1;
    cm = (c == 32) ? 32'hFFFF_FFFF : (32'd1 << c) - 1;
    a = a_in & m;
    b = b_in & m;
    av = longint'(a);
    bv = longint'(b);
    if (s && a[w-1]) av -= longint'(1) << w;
    if (s && b[w-1]) bv -= longint'(1) << w;
    f = (av == bv) ? 3'b100 : (av < bv) ? 3'b010 : 3'b001;
    k = w / c;
    for (int i = 0; i < w / c; i++)
      if (((a >> (w - (i + 1) * c)) & cm) != ((b >> (w - (i + 1) * c)) & cm)) begin
        k = i + 1;
        break;
      end
  endtask

  task automatic xact(input int d, input logic [31:0] a, input logic [31:0] b, input logic s,
                      output int lat, output logic [2:0] f);
    int n;
    n = 0;
    @(negedge clk);
    while (!ordy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", longint'(ordy[d]), 1);
    opa[d] = a;
    opb[d] = b;
    sg[d] = s;
    vin[d] = 1'b1;
    @(posedge clk);
    #1;
    vin[d] = 1'b0;
    opa[d] = $urandom;
    opb[d] = $urandom;
    sg[d] = ~s;
    lat = 0;
    while (!ov[d] && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    f = flags(d);
    @(negedge clk);
    irdy[d] = 1'b1;
    @(posedge clk);
    #1;
    irdy[d] = 1'b0;
    chk("ready_after_handshake", longint'(ordy[d]), 1);
    chk("valid_after_handshake", longint'(ov[d]), 0);
  endtask

  task automatic run_model(input int d, input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [2:0] ef, af;
    int ek, ak;
    model(d, a, b, s, ef, ek);
    xact(d, a, b, s, ak, af);
    chk("rand_flags", longint'(af), longint'(ef));
    chk("rand_latency", longint'(ak), longint'(ek));
  endtask

  initial begin
    vec_t tbl[10];
    int lat, cnt;
    logic [2:0] f;
    logic [31:0] a, b;
    tbl[0] = '{32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100, 8};
    tbl[1] = '{32'h10000000, 32'h20000000, 1'b0, 3'b010, 1};
    tbl[2] = '{32'h12345679, 32'h12345678, 1'b0, 3'b001, 8};
    tbl[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b010, 1};
    tbl[4] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b001, 1};
    tbl[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b010, 1};
    tbl[6] = '{32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b001, 1};
    tbl[7] = '{32'h00000000, 32'h00000000, 1'b1, 3'b100, 8};
    tbl[8] = '{32'h00000010, 32'h00000001, 1'b0, 3'b001, 7};
    tbl[9] = '{32'hF0000005, 32'hF0000003, 1'b1, 3'b001, 8};
    for (int d = 0; d < 3; d++) begin
      vin[d] = 1'b0;
      irdy[d] = 1'b0;
      sg[d] = 1'b0;
      opa[d] = '0;
      opb[d] = '0;
    end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", longint'(ordy[d]), 1);
      chk("reset_valid", longint'(ov[d]), 0);
      chk("reset_flags", longint'(flags(d)), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      xact(0, tbl[i].a, tbl[i].b, tbl[i].s, lat, f);
      chk("tbl_flags", longint'(f), longint'(tbl[i].f));
      chk("tbl_latency", longint'(lat), longint'(tbl[i].k));
    end

    // Backpressure, with requests pulsed during RUN and DONE that must be ignored.
    @(negedge clk);
    opa[0] = 32'd1; opb[0] = 32'd2; sg[0] = 1'b0; vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    @(negedge clk);
    opa[0] = 32'hFFFFFFFF; opb[0] = 32'd0; vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_not_yet_valid", longint'(ov[0]), 0);
    @(posedge clk);
    #1;
    chk("bp_valid", longint'(ov[0]), 1);
    chk("bp_flags", longint'(flags(0)), 3'b010);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vin[0] = (i == 1 || i == 2);
      opa[0] = 32'd0;
      opb[0] = 32'd5;
      @(posedge clk);
      #1;
      chk("bp_hold_valid", longint'(ov[0]), 1);
      chk("bp_hold_flags", longint'(flags(0)), 3'b010);
      chk("bp_hold_not_ready", longint'(ordy[0]), 0);
    end
    @(negedge clk);
    vin[0] = 1'b0;
    irdy[0] = 1'b1;
    @(posedge clk);
    #1;
    irdy[0] = 1'b0;
    chk("bp_idle_ready", longint'(ordy[0]), 1);
    chk("bp_idle_valid", longint'(ov[0]), 0);
    chk("bp_idle_flags_kept", longint'(flags(0)), 3'b010);

    // Reset in RUN at slice index 3.
    @(negedge clk);
    opa[0] = 32'd0; opb[0] = 32'd1; vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_run_ready", longint'(ordy[0]), 1);
    chk("rst_run_valid", longint'(ov[0]), 0);
    chk("rst_run_flags", longint'(flags(0)), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in DONE with a result pending.
    @(negedge clk);
    opa[0] = 32'd1; opb[0] = 32'd0; vin[0] = 1'b1;
    @(posedge clk);
    #1;
    vin[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("rst_done_pre_valid", longint'(ov[0]), 1);
    chk("rst_done_pre_flags", longint'(flags(0)), 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_done_ready", longint'(ordy[0]), 1);
    chk("rst_done_valid", longint'(ov[0]), 0);
    chk("rst_done_flags", longint'(flags(0)), 0);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 32'd5, 32'd5, 1'b0, lat, f);
    chk("post_rst_flags", longint'(f), 3'b100);
    chk("post_rst_latency", longint'(lat), 8);

    for (int d = 0; d < 3; d++)
      for (int s = 0; s < 2; s++) begin
        cnt = (d == 0) ? 300 : 1000;
        for (int i = 0; i < cnt; i++) begin
          a = $urandom;
          case ($urandom_range(0, 3))
            0: b = a;
            1, 2: b = a ^ (32'd1 << $urandom_range(0, ws[d] - 1));
            default: b = $urandom;
          endcase
          run_model(d, a, b, s[0]);
        end
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/comparator_seq.md
# comparator_seq

Parametrised, multi-cycle magnitude comparator that resolves `operand_a` against `operand_b` one CHUNK-bit slice per clock, MSB slice first, with early termination on the first differing slice. It supports signed or unsigned comparison per transaction and a valid/ready handshake on both input and output. It is the sequential, area-lean counterpart of the tree comparators, intended for datapaths where WIDTH is large and single-cycle compare depth is unaffordable.

## Interface

Parameters:
- WIDTH, 32, operand width in bits.
- CHUNK, 4, bits compared per cycle. Must satisfy WIDTH % CHUNK == 0 and 1 <= CHUNK <= WIDTH. NCHUNK = WIDTH/CHUNK.

Ports:
- Clocking: one clock; reset is asynchronous and active-low (`i_clk`, `i_rst_n`).
- i_clk  in  1  clock, all state on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  block can accept a request.
- operand_a  in  WIDTH  first operand.
- operand_b  in  WIDTH  second operand.
- i_signed  in  1  1 = two's-complement compare, 0 = unsigned; sampled with operands.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result.
- o_eq  out  1  operand_a == operand_b.
- o_lt  out  1  operand_a < operand_b.
- o_gt  out  1  operand_a > operand_b.

## Operation

- FSM states: IDLE, RUN, DONE. o_ready = (state == IDLE); o_valid = (state == DONE).
- IDLE: on i_valid & o_ready, register operands into internal a_q/b_q. If i_signed, the MSB of both registered copies is inverted (offset-binary mapping), so the datapath is unsigned only. Clear the slice counter to 0, clear o_eq/o_lt/o_gt, and go to RUN.
- RUN: compare slice idx (slice 0 = bits [WIDTH-1 -: CHUNK], slice idx = bits [WIDTH-1-idx*CHUNK -: CHUNK]).
  - Slices differ: set o_lt = (a_slice < b_slice), o_gt = !o_lt, o_eq = 0, go to DONE.
  - Slices equal and idx == NCHUNK-1: set o_eq = 1, o_lt = o_gt = 0, go to DONE.
  - Slices equal otherwise: idx <= idx + 1, stay in RUN.
- DONE: flags held stable. On i_ready, go to IDLE. i_valid is ignored in RUN and DONE; there is no queuing.
- Flags are exactly one-hot whenever o_valid = 1. They retain their last values in IDLE until the next accept clears them.
- Slice counter width is clog2(NCHUNK), minimum 1 bit. It never wraps, because exit is forced at NCHUNK-1.
- Operands are captured; input changes after the accept edge have no effect.

## Timing

- Reset values: state IDLE, o_valid 0, o_ready 1, o_eq 0, o_lt 0, o_gt 0, counter 0.
- Reset asserted mid-RUN or mid-DONE: the block immediately returns to reset values and the in-flight result is discarded.
- Latency: if the accept occurs at edge T0 and the first differing slice is slice k-1 (1 <= k <= NCHUNK), o_valid rises after edge T0+k. For equal operands, k = NCHUNK.
- The result handshake completes at the edge where o_valid & i_ready are both high. o_ready rises in the following cycle. The earliest next accept is one cycle after that.
- Minimum request period: k+2 cycles.
- Backpressure: with i_ready low, DONE and the flags hold indefinitely.
- CHUNK == WIDTH: the compare always resolves in 1 cycle.

## Test plan

- Unsigned equal: WIDTH=32, CHUNK=4, a=b=0xDEADBEEF, i_signed=0 -> o_valid rises 8 edges after accept with o_eq=1, o_lt=o_gt=0.
- Early exit: a=0x10000000, b=0x20000000, unsigned -> o_lt=1 after 1 edge. Then a=0x12345679, b=0x12345678 -> o_gt=1 after 8 edges.
- Signed vs. unsigned: a=0xFFFFFFFF, b=0x00000001 -> i_signed=1 gives o_lt=1 after 1 edge; i_signed=0 gives o_gt=1. a=0x80000000, b=0x7FFFFFFF, signed -> o_lt=1.
- Backpressure/ignore: hold i_ready=0 for 5 cycles in DONE -> o_valid and flags stay constant. Pulse i_valid with new operands during RUN and DONE -> that request is not accepted and the result is unchanged.
- Reset mid-operation: assert i_rst_n=0 asynchronously during RUN at idx=3 -> outputs go to reset values immediately. After release, a new request a=5, b=5 completes normally with o_eq=1.
- Parameter sweep: WIDTH=8/CHUNK=8 and WIDTH=16/CHUNK=1, with 1000 random operand pairs per mode -> flags match the reference compare and latency matches the formula above.
